// File: rtl/vram_write_queue.sv
// CPU-to-VRAM write queue: buffers CPU writes in a circular FIFO and releases
// them to VRAM one per cycle whenever video timing says writes are permitted.
module vram_write_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ready,
    input  logic                     writable,
    output logic                     vram_we,
    output logic [ADDR_W-1:0]        vram_addr,
    output logic [DATA_W-1:0]        vram_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic                     drained
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [EW-1:0] r_last;
    logic          r_overflow;
    logic          r_drained;

    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head_entry;
    logic [EW-1:0] w_out_entry;

    assign wr_ready = (r_count != CW'(DEPTH));
    assign w_push   = wr_valid & wr_ready;
    // rst gates the strobe so nothing reaches VRAM in the cycle reset is sampled.
    assign w_pop    = writable & (r_count != '0) & ~rst;

    assign w_head_entry = r_mem[r_head];
    // When empty, show the last entry written out; r_last is reset so the
    // port never exposes an unwritten storage slot.
    assign w_out_entry  = (r_count != '0) ? w_head_entry : r_last;

    assign vram_we   = w_pop;
    assign vram_addr = w_out_entry[EW-1:DATA_W];
    assign vram_data = w_out_entry[DATA_W-1:0];
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drained   = r_drained;

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_tail] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_last     <= '0;
            r_overflow <= 1'b0;
            r_drained  <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
                r_last <= w_head_entry;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Set takes priority over a simultaneous clear.
            if (wr_valid && !wr_ready) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
            r_drained <= w_pop & ~w_push & (r_count == CW'(1));
        end
    end

endmodule

// File: doc/vram_write_queue.md
VRAM_WRITE_QUEUE -- requirements
Module: vram_write_queue

Interface
REQ-001 Parameter: DEPTH, 16, FIFO entries; power of two, 4..64.
REQ-002 Parameter: ADDR_W, 12, VRAM address width.
REQ-003 Parameter: DATA_W, 8, VRAM data width.
REQ-004 Port: clk  input  1  pixel clock, 12.5875 MHz, shared with video timing.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: wr_valid  input  1  CPU write request.
REQ-007 Port: wr_addr  input  ADDR_W  CPU write address.
REQ-008 Port: wr_data  input  DATA_W  CPU write data.
REQ-009 Port: wr_ready  output  1  queue can accept a write this cycle.
REQ-010 Port: writable  input  1  high when VRAM writes are permitted (outside vertical visible region), from video timing.
REQ-011 Port: vram_we  output  1  VRAM write strobe.
REQ-012 Port: vram_addr  output  ADDR_W  VRAM write address.
REQ-013 Port: vram_data  output  DATA_W  VRAM write data.
REQ-014 Port: count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 Port: overflow  output  1  sticky flag: write attempted while full.
REQ-016 Port: overflow_clr  input  1  clears overflow.
REQ-017 Port: drained  output  1  one-cycle pulse when queue empties through a pop.

Function
REQ-018 Circular FIFO: registered head pointer, tail pointer and occupancy counter.
REQ-019 wr_ready = (count != DEPTH), combinational from registered state only; no dependence on wr_valid or writable.
REQ-020 Push: wr_valid & wr_ready at a rising edge stores {wr_addr, wr_data} at tail; tail advances modulo DEPTH.
REQ-021 Pop condition: writable & (count != 0); each pop removes one entry per cycle.
REQ-022 vram_we = pop condition, combinational; vram_addr/vram_data = head entry, combinational.
REQ-023 When vram_we = 0, vram_addr and vram_data hold the head entry value or last value; do not care, but no X after reset.
REQ-024 Latency: entry pushed at edge N is drivable on VRAM port in cycle N+1 at earliest (writable high, queue otherwise empty).
REQ-025 Order: VRAM writes occur in exact push order; no entry dropped or duplicated.
REQ-026 Simultaneous push and pop: both take effect; count unchanged; when count = 1, the pushed entry becomes head next cycle.
REQ-027 Push when full: refused (wr_ready = 0), even if a pop occurs in the same cycle.
REQ-028 Pointer wrap: tail/head from DEPTH-1 wrap to 0 with no bubble.
REQ-029 writable falling: no pop in any cycle where writable = 0; draining resumes on next writable high cycle from same head.
REQ-030 overflow sets on edge where wr_valid & !wr_ready; clears on overflow_clr; simultaneous set and clear -> set wins.
REQ-031 drained pulses high for the cycle after a pop that takes count from 1 to 0 with no concurrent push.
REQ-032 count is always the number of stored entries; range 0..DEPTH, never wraps.

Reset
REQ-033 rst synchronous, active-high, priority over all push/pop/clear activity.
REQ-034 Reset values: head = 0, tail = 0, count = 0, overflow = 0, drained = 0, wr_ready = 1, vram_we = 0.
REQ-035 rst mid-drain: queue contents discarded; vram_we low the cycle rst is sampled and every following cycle until a new push occurs.
REQ-036 Storage array needs no reset; vram_addr/vram_data read 0 after reset until first push.

Verification
REQ-037 writable=0, push 16 entries (addr 0x000..0x00F, data 0xA0..0xAF) -> count=16, wr_ready=0, vram_we never high.
REQ-038 From full, 17th push with writable=0 -> refused, overflow=1; overflow_clr pulse -> overflow=0.
REQ-039 From full, writable=1 -> 16 consecutive vram_we cycles, addr 0x000..0x00F in order, drained pulse once after last write, count=0.
REQ-040 writable=1, push one write per cycle, 40 cycles -> each entry written 1 cycle after push, count stays <=1, pointers wrap twice, data matches.
REQ-041 Drain 8 entries, drop writable after 3 writes for 100 cycles, then raise -> remaining 5 written in order, none during low window.
REQ-042 Assert rst with count=9 while draining -> next cycle count=0, vram_we=0, wr_ready=1, overflow=0; next push then drains normally.
